mo_line_buffer: RTL and testbench

MO_LINE_BUFFER -- requirements
Module: mo_line_buffer

---
 rtl/mo_line_buffer.sv | 121 ++++++++++++
 tb/tb_mo_line_buffer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mo_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : mo_line_buffer
// Brief    : Double-banked motion-object line buffer with erase-after-read.
// Revision : 1.0 - initial release
// ============================================================================
module mo_line_buffer #(
    parameter int         XBITS  = 8,
    parameter logic [2:0] TRANSP = 3'b111
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce5,
    input  logic [2:0]       AR,
    input  logic             wr_en,
    input  logic             load_x,
    input  logic [XBITS-1:0] x_start,
    input  logic             line_toggle,
    input  logic [XBITS-1:0] rd_x,
    output logic [2:0]       mo_pix,
    output logic             busy
);

    localparam int               c_depth    = 1 << XBITS;
    localparam logic [0:0]       ST_CLEAR   = 1'b0;
    localparam logic [0:0]       ST_RUN     = 1'b1;
    localparam logic [XBITS:0]   c_clr_last = {(XBITS+1){1'b1}};
    localparam logic [XBITS-1:0] c_one      = {{(XBITS-1){1'b0}}, 1'b1};

    logic [0:0]       r_state;
    logic [XBITS:0]   r_clr;
    logic             r_wbank;
    logic [XBITS-1:0] r_wx;
    logic [2:0]       r_pix;

    logic             w_run_ce;
    logic             w_wr;
    logic [XBITS-1:0] w_col;
    logic [2:0]       w_rdata [2];
    logic [2:0]       w_rd;

    assign w_run_ce = (r_state == ST_RUN) && ce5;
    assign w_col    = load_x ? x_start : r_wx;
    assign w_wr     = w_run_ce && wr_en && (AR != TRANSP);
    assign w_rd     = r_wbank ? w_rdata[0] : w_rdata[1];

    // Each bank has a single write port: sweep, object write or erase,
    // selected by whether it is currently the write or the read bank.
    genvar b;
    generate
        for (b = 0; b < 2; b++) begin : g_bank
            localparam logic c_bank = 1'(b);
            logic [2:0]       r_mem [c_depth];
            logic             w_we;
            logic [XBITS-1:0] w_addr;
            logic [2:0]       w_din;

            always_comb begin
                w_we   = 1'b0;
                w_addr = rd_x;
                w_din  = TRANSP;
                if (r_state == ST_CLEAR) begin
                    w_we   = (r_clr[XBITS] == c_bank);
                    w_addr = r_clr[XBITS-1:0];
                end else if (r_wbank == c_bank) begin
                    w_we   = w_wr;
                    w_addr = w_col;
                    w_din  = AR;
                end else begin
                    w_we   = w_run_ce;
                end
            end

            always_ff @(posedge clk) begin
                if (w_we) begin
                    r_mem[w_addr] <= w_din;
                end
            end

            assign w_rdata[b] = r_mem[rd_x];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_CLEAR;
            r_clr   <= '0;
            r_wbank <= 1'b0;
            r_wx    <= '0;
            r_pix   <= TRANSP;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_clr <= r_clr + 1'b1;
                    r_pix <= TRANSP;
                    if (r_clr == c_clr_last) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    if (ce5) begin
                        r_pix <= w_rd;
                        if (wr_en) begin
                            r_wx <= w_col + c_one;
                        end else if (load_x) begin
                            r_wx <= x_start;
                        end
                        if (line_toggle) begin
                            r_wbank <= ~r_wbank;
                        end
                    end
                end
            endcase
        end
    end

    assign mo_pix = r_pix;
    assign busy   = (r_state == ST_CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_mo_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mo_line_buffer
// Brief    : Directed + randomized bench for mo_line_buffer against a line model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mo_line_buffer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ce5 = 1'b0;
    logic [2:0] AR = 3'd0;
    logic       wr_en = 1'b0;
    logic       load_x = 1'b0;
    logic [7:0] x_start = 8'd0;
    logic       line_toggle = 1'b0;
    logic [7:0] rd_x = 8'd0;
    logic [2:0] mo_pix;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    // Line model: two 256-entry banks, written/read by the stated rules.
    int m_mem [2][256];
    int m_wbank = 0;
    int m_wx    = 0;
    int m_pix   = 7;
    int m_busy  = 1;
    int m_cnt   = 0;

    mo_line_buffer #(.XBITS(8), .TRANSP(3'b111)) dut (
        .clk         (clk),
        .reset       (reset),
        .ce5         (ce5),
        .AR          (AR),
        .wr_en       (wr_en),
        .load_x      (load_x),
        .x_start     (x_start),
        .line_toggle (line_toggle),
        .rd_x        (rd_x),
        .mo_pix      (mo_pix),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input bit r, input bit c, input int ar, input bit we,
                       input bit ld, input int xs, input bit tg, input int rx);
        int col;
        reset = r; ce5 = c; AR = 3'(ar); wr_en = we; load_x = ld;
        x_start = 8'(xs); line_toggle = tg; rd_x = 8'(rx);
        @(posedge clk);
        if (r) begin
            m_busy = 1; m_cnt = 0; m_wbank = 0; m_wx = 0; m_pix = 7;
        end else if (m_busy != 0) begin
            m_cnt++;
            if (m_cnt == 512) begin
                m_busy = 0;
                for (int k = 0; k < 256; k++) begin
                    m_mem[0][k] = 7;
                    m_mem[1][k] = 7;
                end
            end
        end else if (c) begin
            col = ld ? xs : m_wx;
            if (we) begin
                if (ar != 7) m_mem[m_wbank][col] = ar;
                m_wx = (col + 1) % 256;
            end else if (ld) begin
                m_wx = xs;
            end
            m_pix = m_mem[1 - m_wbank][rx];
            m_mem[1 - m_wbank][rx] = 7;
            if (tg) m_wbank = 1 - m_wbank;
        end
        #1;
        check("mo_pix", int'(mo_pix), m_pix);
        check("busy", int'(busy), m_busy);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic wr(input int ar);
        cyc(0, 1, ar, 1, 0, 0, 0, 0);
    endtask
    task automatic ldx(input int xs);
        cyc(0, 1, 0, 0, 1, xs, 0, 0);
    endtask
    task automatic tog();
        cyc(0, 1, 0, 0, 0, 0, 1, 0);
    endtask
    task automatic rd(input int rx);
        cyc(0, 1, 0, 0, 0, 0, 0, rx);
    endtask

    initial begin
        int exp34 [4];
        exp34 = '{1, 7, 3, 5};

        // Reset state and clear sweep timing
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        check("rst_busy", int'(busy), 1);
        check("rst_pix", int'(mo_pix), 7);
        idle(511);
        check("busy_511", int'(busy), 1);
        idle(1);
        check("busy_512", int'(busy), 0);
        tog();
        for (int x = 0; x < 256; x++) begin
            rd(x);
            check("clr_rd", int'(mo_pix), 7);
        end

        // Four pixels from column 10, read back then erased
        ldx(10);
        wr(1); wr(7); wr(3); wr(5);
        tog();
        for (int i = 0; i < 4; i++) begin
            rd(10 + i);
            check("rd34", int'(mo_pix), exp34[i]);
        end
        for (int i = 0; i < 4; i++) begin
            rd(10 + i);
            check("erase34", int'(mo_pix), 7);
        end

        // Column counter wrap
        ldx(254);
        wr(2); wr(2); wr(2);
        tog();
        rd(254); check("wrap254", int'(mo_pix), 2);
        rd(255); check("wrap255", int'(mo_pix), 2);
        rd(0);   check("wrap0", int'(mo_pix), 2);

        // Overlapping objects: last opaque wins, transparent leaves earlier
        cyc(0, 1, 4, 1, 1, 20, 0, 0);
        cyc(0, 1, 6, 1, 1, 20, 0, 0);
        tog();
        rd(20); check("ovl_opaque", int'(mo_pix), 6);
        cyc(0, 1, 4, 1, 1, 20, 0, 0);
        cyc(0, 1, 7, 1, 1, 20, 0, 0);
        tog();
        rd(20); check("ovl_transp", int'(mo_pix), 4);

        // Write in the toggle cycle lands in the pre-toggle bank
        ldx(50);
        cyc(0, 1, 3, 1, 0, 0, 1, 0);
        rd(50); check("wr_tog", int'(mo_pix), 3);

        // Reset mid-line with activity during the sweep
        ldx(100);
        wr(1); wr(2); wr(3);
        cyc(1, 1, 5, 1, 0, 0, 0, 0);
        for (int i = 0; i < 512; i++) begin
            cyc(0, 1, $urandom_range(0, 6), 1, $urandom_range(0, 1),
                $urandom_range(0, 255), $urandom_range(0, 1), $urandom_range(0, 255));
            if (i == 511) check("rst_mid_busy", int'(busy), 0);
            else          check("rst_mid_pix", int'(mo_pix), 7);
        end
        for (int p = 0; p < 2; p++) begin
            for (int x = 0; x < 256; x++) begin
                rd(x);
                check("post_rst", int'(mo_pix), 7);
            end
            tog();
        end

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 1499) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                $urandom_range(0, 15) == 0, $urandom_range(0, 255),
                $urandom_range(0, 63) == 0, $urandom_range(0, 255));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
